memory_arbiter: RTL

Sits directly downstream of request_unit. It takes the instruction-fetch request (imemRen/imemaddr) and the data request (dmmRen/dmmWen/dmmaddr/dmmstore), serialises them onto the single shared memory bus, and returns the read data to request_unit. It also returns the i_ready/d_ready completion pulses that request_unit uses to clear its latched data request. A watchdog reports bus transactions that never complete.

---
 rtl/memory_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises instruction-fetch and data requests onto one shared memory bus.
//
// Ports:
//   CLK, RST                     clock (rising edge), asynchronous active-high reset
//   imemRen, imemaddr            instruction fetch request and address
//   dmmRen, dmmWen               data read / write request (write wins if both)
//   dmmaddr, dmmstore            data address and write data
//   imemload, dmmload            registered read results, held until the next completion
//   i_ready, d_ready             one-cycle completion pulses (high during RESP)
//   i_err, d_err                 set with the ready pulse when the access timed out
//   bus_ren, bus_wen             registered bus strobes
//   bus_addr, bus_wdata          registered bus address / write data, stable per transfer
//   bus_rdata, bus_ack           bus read data and transfer-complete handshake
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemRen,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              dmmRen,
    input  logic              dmmWen,
    input  logic [ADDR_W-1:0] dmmaddr,
    input  logic [DATA_W-1:0] dmmstore,
    output logic [DATA_W-1:0] imemload,
    output logic [DATA_W-1:0] dmmload,
    output logic              i_ready,
    output logic              d_ready,
    output logic              i_err,
    output logic              d_err,
    output logic              bus_ren,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, INSTR, RESP} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic last_data;
    logic data_req, pick_instr, busy, expire, done;

    assign data_req   = dmmRen | dmmWen;
    // Fetch wins when it is alone, or when data was served last (anti-starvation).
    assign pick_instr = imemRen & (~data_req | last_data);
    assign busy       = (state == DATA) | (state == INSTR);
    assign expire     = (TIMEOUT != 0) && (cnt == LAST);
    assign done       = busy & (bus_ack | expire);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        state_nx = pick_instr ? INSTR : (data_req ? DATA : IDLE);
            DATA, INSTR: state_nx = (bus_ack | expire) ? RESP : state;
            RESP:        state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            imemload  <= '0;
            dmmload   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            cnt       <= '0;
            last_data <= 1'b0;
        end else begin
            i_ready <= done & (state == INSTR);
            d_ready <= done & (state == DATA);
            // A simultaneous ack takes precedence over the timeout.
            i_err   <= done & (state == INSTR) & ~bus_ack;
            d_err   <= done & (state == DATA) & ~bus_ack;
            cnt     <= busy ? cnt + 1'b1 : '0;
            if (state == IDLE) begin
                if (pick_instr) begin
                    bus_ren   <= 1'b1;
                    bus_addr  <= imemaddr;
                    bus_wdata <= '0;
                    last_data <= 1'b0;
                end else if (data_req) begin
                    bus_ren   <= ~dmmWen;
                    bus_wen   <= dmmWen;
                    bus_addr  <= dmmaddr;
                    bus_wdata <= dmmWen ? dmmstore : '0;
                    last_data <= 1'b1;
                end
            end
            if (done) begin
                bus_ren <= 1'b0;
                bus_wen <= 1'b0;
                // bus_wen still reflects the operation of the transfer being closed.
                if (bus_ack && state == INSTR)   imemload <= bus_rdata;
                else if (bus_ack && !bus_wen)    dmmload  <= bus_rdata;
            end
        end
    end
endmodule
